// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ (0x03) from a one-cycle-latency memory port and
// JEDEC ID (0x9F). All SPI pins are oversampled in the clk domain.
`timescale 1ns/1ps
module spi_flash_responder #(
  parameter int          ADDR_BITS = 16,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 spi_csb,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 mem_valid,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int RXW = (ADDR_BITS > 8) ? ADDR_BITS - 1 : 7;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, IGNORE} state_e;

  state_e state_q, state_d;

  logic csb_s1_q, csb_s2_q, csb_prev_q;
  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic mosi_s1_q, mosi_s2_q;
  logic [1:0] fill_q;
  logic armed_q;

  logic [RXW-1:0]       rx_q;
  logic [4:0]           bit_cnt_q;
  logic [7:0]           tx_q, hold_q;
  logic [23:0]          id_q;
  logic                 first_q, rd_pend_q, pend_tx_q;
  logic                 miso_q, oe_q, mem_valid_q;
  logic [ADDR_BITS-1:0] mem_addr_q;

  logic csb_rise, csb_fall, sclk_rise, sclk_fall, start;
  logic [7:0] opcode, data_src;
  logic [ADDR_BITS-1:0] addr_low;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csb_s1_q    <= 1'b1;
      csb_s2_q    <= 1'b1;
      csb_prev_q  <= 1'b1;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      fill_q      <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      csb_s1_q    <= spi_csb;
      csb_s2_q    <= csb_s1_q;
      csb_prev_q  <= csb_s2_q;
      sclk_s1_q   <= spi_clk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      mosi_s1_q   <= spi_mosi;
      mosi_s2_q   <= mosi_s1_q;
      fill_q      <= {fill_q[0], 1'b1};
      // Only arm once the synchronizer holds a real idle level, so a csb that was
      // already low when reset released is not mistaken for a fresh select.
      armed_q     <= armed_q | (fill_q[1] & csb_s2_q);
    end
  end

  assign csb_rise  = csb_s2_q & ~csb_prev_q;
  assign csb_fall  = ~csb_s2_q & csb_prev_q;
  assign start     = csb_fall & armed_q;
  assign sclk_rise = sclk_s2_q & ~sclk_prev_q & ~csb_rise;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q & ~csb_rise;
  assign opcode    = {rx_q[6:0], mosi_s2_q};
  assign addr_low  = {rx_q[ADDR_BITS-2:0], mosi_s2_q};
  assign data_src  = first_q ? tx_q : hold_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (csb_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = CMD;
        CMD:
          if (sclk_rise && bit_cnt_q == 5'd7) begin
            case (opcode)
              8'h03:   state_d = ADDR;
              8'h9F:   state_d = ID;
              default: state_d = IGNORE;
            endcase
          end
        ADDR: if (sclk_rise && bit_cnt_q == 5'd23) state_d = DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy    = ~csb_s2_q;
    cmd_err = 1'b0;
    if (state_q == CMD && sclk_rise && bit_cnt_q == 5'd7 &&
        opcode != 8'h03 && opcode != 8'h9F && opcode != 8'hAB && opcode != 8'hFF)
      cmd_err = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      hold_q      <= '0;
      id_q        <= '0;
      first_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      pend_tx_q   <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      mem_valid_q <= 1'b0;
      rd_pend_q   <= mem_valid_q;
      // Read data lands one cycle after the strobe; after an abort it is dropped.
      if (rd_pend_q) begin
        pend_tx_q <= 1'b0;
        if (state_q == DATA) begin
          if (pend_tx_q) tx_q   <= mem_rdata;
          else           hold_q <= mem_rdata;
        end
      end
      if (csb_rise) begin
        miso_q <= 1'b0;
        oe_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE:
            if (start) begin
              bit_cnt_q <= '0;
              rx_q      <= '0;
              pend_tx_q <= 1'b0;
            end
          CMD:
            if (sclk_rise) begin
              rx_q <= {rx_q[RXW-2:0], mosi_s2_q};
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                id_q      <= JEDEC_ID;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          ADDR:
            if (sclk_rise) begin
              rx_q <= {rx_q[RXW-2:0], mosi_s2_q};
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q   <= '0;
                mem_valid_q <= 1'b1;
                mem_addr_q  <= addr_low;
                pend_tx_q   <= 1'b1;
                first_q     <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          DATA:
            if (sclk_fall) begin
              oe_q      <= 1'b1;
              bit_cnt_q <= {2'b00, bit_cnt_q[2:0] + 3'd1};
              if (bit_cnt_q[2:0] == 3'd0) begin
                // Byte boundary: start the next byte and prefetch the one after it.
                miso_q      <= data_src[7];
                tx_q        <= {data_src[6:0], 1'b0};
                first_q     <= 1'b0;
                mem_valid_q <= 1'b1;
                mem_addr_q  <= mem_addr_q + 1'b1;
              end else begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end
          ID:
            if (sclk_fall) begin
              oe_q   <= 1'b1;
              miso_q <= id_q[23];
              id_q   <= {id_q[22:0], 1'b0};
            end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a bit-banged SPI master, a mem[n]=n[7:0]
// memory model, and scoreboard queues for expected MISO bytes and memory addresses.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_csb = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, mem_valid, busy, cmd_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int mv_cnt = 0;
  bit oe_seen = 1'b0;
  bit miso_seen = 1'b0;

  logic [7:0]  exp_q[$];
  logic [15:0] addr_q[$];

  spi_flash_responder #(.ADDR_BITS(16), .JEDEC_ID(24'hEF4016)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .spi_csb    (spi_csb),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  // Memory: data is only meaningful the cycle after the strobe.
  always @(posedge clk) mem_rdata <= mem_valid ? mem_addr[7:0] : 8'hA5;

  always @(negedge clk) begin
    logic [15:0] ea;
    if (cmd_err) err_cnt++;
    if (spi_miso_oe) oe_seen = 1'b1;
    if (spi_miso) miso_seen = 1'b1;
    if (mem_valid) begin
      mv_cnt++;
      tests++;
      if (addr_q.size() == 0) begin
        fails++;
        $error("FAIL mem_valid_unexpected: observed addr %h, expected no strobe", mem_addr);
      end else begin
        ea = addr_q.pop_front();
        assert (mem_addr === ea) else begin
          fails++;
          $error("FAIL mem_addr: observed %h expected %h", mem_addr, ea);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    if (spi_clk) spi_clk = 1'b0;
    spi_mosi = b;
    #HALF;
    spi_clk = 1'b1;
    r = spi_miso;
    #HALF;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], r[i]);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    spi_byte(b, r);
  endtask

  task automatic get_byte(input string tag);
    logic [7:0] r;
    logic [7:0] e;
    spi_byte(8'h00, r);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed %h expected nothing queued", tag, r);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'h0, r}, {24'h0, e});
    end
    check({tag, "_oe"}, {31'h0, spi_miso_oe}, 32'h1);
    $display("[TB] %s byte %h", tag, r);
  endtask

  task automatic cs_begin();
    spi_csb = 1'b0;
    #HALF;
  endtask

  // csb rises while spi_clk is still high, so no trailing falling edge is seen.
  task automatic cs_end();
    spi_csb = 1'b1;
    #HALF;
    spi_clk = 1'b0;
    #(2 * HALF);
  endtask

  initial begin
    logic b;
    int mv0, err0;

    // Reset, with csb asserted to show the synchronizers are held idle.
    spi_csb = 1'b0;
    #50;
    check("reset_outputs", {11'h0, spi_miso, spi_miso_oe, mem_valid, mem_addr, busy, cmd_err}, 32'h0);
    spi_csb = 1'b1;
    #20;
    resetn = 1'b1;
    #100;
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Plain read from 0x1234.
    for (int i = 0; i < 5; i++) addr_q.push_back(16'h1234 + 16'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h34 + 8'(i));
    cs_begin();
    check("busy_active", {31'h0, busy}, 32'h1);
    send(8'h03); send(8'h00); send(8'h12); send(8'h34);
    for (int i = 0; i < 4; i++) get_byte("read_1234");
    cs_end();
    check("end_oe", {31'h0, spi_miso_oe}, 32'h0);
    check("end_busy", {31'h0, busy}, 32'h0);
    check("addr_q_drained_1", addr_q.size(), 0);

    // Read wrapping through 0xFFFF.
    addr_q.push_back(16'hFFFE); addr_q.push_back(16'hFFFF);
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0001); addr_q.push_back(16'h0002);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    cs_begin();
    send(8'h03); send(8'h00); send(8'hFF); send(8'hFE);
    for (int i = 0; i < 4; i++) get_byte("read_wrap");
    cs_end();
    check("addr_q_drained_2", addr_q.size(), 0);

    // JEDEC ID.
    mv0 = mv_cnt;
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16); exp_q.push_back(8'h00);
    cs_begin();
    send(8'h9F);
    for (int i = 0; i < 4; i++) get_byte("jedec_id");
    cs_end();
    check("id_no_mem_valid", mv_cnt - mv0, 0);
    check("id_end_miso", {31'h0, spi_miso}, 32'h0);

    // Unsupported opcode.
    err0 = err_cnt;
    mv0 = mv_cnt;
    oe_seen = 1'b0;
    miso_seen = 1'b0;
    cs_begin();
    send(8'h5A); send(8'hFF); send(8'hFF);
    cs_end();
    check("bad_op_cmd_err", err_cnt - err0, 1);
    check("bad_op_oe", {31'h0, oe_seen}, 32'h0);
    check("bad_op_miso", {31'h0, miso_seen}, 32'h0);
    check("bad_op_no_mem", mv_cnt - mv0, 0);
    $display("[TB] opcode 5A cmd_err pulses %0d", err_cnt - err0);

    // 0xAB is silently ignored.
    err0 = err_cnt;
    cs_begin();
    send(8'hAB); send(8'h00);
    cs_end();
    check("ab_no_cmd_err", err_cnt - err0, 0);

    // Abort three bits into the second data byte, then restart cleanly.
    addr_q.push_back(16'h0155); addr_q.push_back(16'h0156); addr_q.push_back(16'h0157);
    exp_q.push_back(8'h55);
    cs_begin();
    send(8'h03); send(8'h00); send(8'h01); send(8'h55);
    get_byte("abort_first");
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
    cs_end();
    check("abort_oe", {31'h0, spi_miso_oe}, 32'h0);
    check("abort_miso", {31'h0, spi_miso}, 32'h0);
    addr_q.push_back(16'h0010); addr_q.push_back(16'h0011);
    exp_q.push_back(8'h10);
    cs_begin();
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    get_byte("restart_0010");
    cs_end();

    // Asynchronous reset during the address phase.
    cs_begin();
    send(8'h03); send(8'h00);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", {11'h0, spi_miso, spi_miso_oe, mem_valid, mem_addr, busy, cmd_err}, 32'h0);
    spi_csb = 1'b1;
    spi_clk = 1'b0;
    #49;
    resetn = 1'b1;
    #200;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0001);
    exp_q.push_back(8'h00);
    cs_begin();
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    get_byte("after_reset_0000");
    cs_end();

    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter: ADDR_BITS, 16, width of the memory address; the low ADDR_BITS of the 24-bit SPI address are used.
REQ-002 Parameter: JEDEC_ID, 24'hEF4016, 3-byte ID returned by command 0x9F, MSB byte first.
REQ-003 Port: clk  in  1  sole clock; all state is in this domain.
REQ-004 Port: resetn  in  1  asynchronous active-low reset.
REQ-005 Port: spi_csb  in  1  chip select from the SPI master, active low, asynchronous to clk.
REQ-006 Port: spi_clk  in  1  SPI clock, mode 0, asynchronous to clk.
REQ-007 Port: spi_mosi  in  1  serial data from the master (io0).
REQ-008 Port: spi_miso  out  1  serial data to the master (io1).
REQ-009 Port: spi_miso_oe  out  1  output enable for spi_miso.
REQ-010 Port: mem_valid  out  1  one-cycle memory read strobe.
REQ-011 Port: mem_addr  out  ADDR_BITS  memory read address.
REQ-012 Port: mem_rdata  in  8  read data, valid exactly 1 clk after mem_valid.
REQ-013 Port: busy  out  1  high while chip select is asserted.
REQ-014 Port: cmd_err  out  1  one-cycle pulse on receipt of an unsupported opcode.

Function
REQ-015 The block SHALL pass spi_csb, spi_clk and spi_mosi through 2-flop synchronizers, and detect spi_clk edges by comparing the synchronized value with its previous value.
REQ-016 The block SHALL require a spi_clk high and low time of at least 4 clk periods; faster SPI clocks are out of scope.
REQ-017 The block SHALL sample spi_mosi on each detected rising spi_clk edge and update spi_miso on each detected falling edge; bits are MSB first.
REQ-018 The FSM SHALL have states IDLE, CMD, ADDR, DATA, ID and IGNORE.
REQ-019 IDLE -> CMD on synchronized spi_csb falling; the bit counter and the shift register SHALL clear.
REQ-020 CMD: after 8 bits, the FSM SHALL take one of these transitions: opcode 0x03 -> ADDR; 0x9F -> ID; 0xAB or 0xFF -> IGNORE with no cmd_err; any other opcode -> IGNORE with a cmd_err pulse in the cycle the 8th bit is sampled.
REQ-021 ADDR: after 24 bits, the FSM SHALL drive mem_valid for 1 clk with mem_addr equal to addr[ADDR_BITS-1:0], load mem_rdata into the tx shift register on the following clk, and enter DATA.
REQ-022 DATA: on each falling edge, the block SHALL shift out the next bit, with spi_miso_oe=1 from the first falling edge in DATA.
REQ-023 DATA prefetch: when bit 7 of a byte is driven, the block SHALL issue mem_valid at address+1 and place the result in a holding register.
REQ-024 DATA byte boundary: the holding register SHALL load into the shift register at the falling edge following bit 0.
REQ-025 The DATA address SHALL increment modulo 2^ADDR_BITS (wraps 0xFFFF -> 0x0000 for ADDR_BITS=16); the stream is unbounded while csb is low.
REQ-026 ID: the block SHALL shift out JEDEC_ID[23:0] MSB first, then 0x00 bytes indefinitely.
REQ-027 IGNORE: the block SHALL drop all further MOSI bits, keep spi_miso_oe=0 and spi_miso=0, and issue no mem_valid.
REQ-028 Synchronized spi_csb rising in any state SHALL abort to IDLE within 1 clk, dropping spi_miso_oe and spi_miso to 0 and cancelling partial bytes; a mem_valid already issued completes and its data is discarded.
REQ-029 If spi_csb rises on the same clk as a detected spi_clk edge, the csb rise SHALL win and the edge SHALL be ignored.
REQ-030 busy SHALL equal the inverted synchronized spi_csb whenever the block is out of reset.
REQ-031 At most one mem_valid SHALL be outstanding at any time; mem_valid SHALL never assert outside ADDR completion or DATA prefetch.

Reset
REQ-032 While resetn=0, the FSM SHALL be in IDLE and all outputs SHALL be 0: spi_miso, spi_miso_oe, mem_valid, mem_addr, busy, cmd_err.
REQ-033 All synchronizer flops SHALL reset to the idle bus state: csb=1, clk=0, mosi=0.
REQ-034 Reset assertion mid-transaction SHALL take effect immediately (asynchronous); after release, the block SHALL wait for a fresh csb falling edge before accepting a command.

Verification
REQ-035 Read 03 00 12 34 with mem[n]=n[7:0], 4 bytes clocked -> MISO 0x34 0x35 0x36 0x37; mem_addr 0x1234..0x1237 then 0x1238 prefetched.
REQ-036 Read 03 00 FF FE, 4 bytes -> MISO from mem 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
REQ-037 Command 9F, 4 bytes -> MISO 0xEF 0x40 0x16 0x00; mem_valid never asserted.
REQ-038 Opcode 0x5A then 16 clocks -> one cmd_err pulse, spi_miso_oe stays 0, no mem_valid.
REQ-039 csb raised after 3 bits of the second data byte, then 03 00 00 10 -> clean restart with MISO = mem[0x0010].
REQ-040 resetn pulsed low during ADDR -> all outputs 0 immediately; next transaction 03 00 00 00 returns mem[0] correctly.
